// File: rtl/bus_arbiter_3to1_pkg.sv
// bus_arbiter_3to1_pkg: shared select, state and one-hot grant encodings for the 3:1 bus arbiter.
package bus_arbiter_3to1_pkg;
  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_0 = 3'b001;
  localparam logic [2:0] GNT_1 = 3'b010;
  localparam logic [2:0] GNT_2 = 3'b100;
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == SEL_IN2) ? SEL_IN0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/bus_arbiter_3to1_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin pick, scanning ptr, ptr+1, ptr+2 (mod 3).
module rr_pick3
  import bus_arbiter_3to1_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] pick,
  output logic [1:0] index
);
  logic [1:0] i0, i1, i2;
  always_comb begin
    i0 = (ptr == 2'd3) ? SEL_IN0 : ptr;
    i1 = next_idx(i0);
    i2 = next_idx(i1);
    index = req[i0] ? i0 : req[i1] ? i1 : req[i2] ? i2 : SEL_IN0;
    pick = (|req) ? (GNT_0 << index) : GNT_NONE;
  end
endmodule

// File: rtl/bus_arbiter_3to1.sv
// bus_arbiter_3to1: round-robin arbiter driving a 32-bit 3:1 mux onto a valid/ready consumer.
// Define ARB_FIXED_PRIO_EN for strict priority 0>1>2 (pointer held at 0).
module bus_arbiter_3to1
  import bus_arbiter_3to1_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [2:0]       grant,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [2:0]       ack
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);
  state_t state;
  logic [1:0] ptr, ptr_nxt, index;
  logic [2:0] pick;
  logic [CW-1:0] beat_cnt;
  logic beat, release_now;
  rr_pick3 u_pick (.req(req), .ptr(ptr), .pick(pick), .index(index));
`ifdef ARB_FIXED_PRIO_EN
  assign ptr_nxt = SEL_IN0;
`else
  assign ptr_nxt = next_idx(sel);
`endif
  assign out_valid = (state == ST_GRANT) && |(grant & req);
  assign beat = out_valid & out_ready;
  assign ack = grant & {3{beat}};
  assign out_data = (sel == SEL_IN1) ? data1 : (sel == SEL_IN2) ? data2 : data0;
  // A withdrawn req drops out_valid, which releases the grant on the next edge
  assign release_now = !out_valid || (beat && beat_cnt == LAST);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr <= SEL_IN0;
      beat_cnt <= '0;
      grant <= GNT_NONE;
      sel <= SEL_IN0;
    end else if (state == ST_IDLE) begin
      if (|req) begin
        state <= ST_GRANT;
        grant <= pick;
        sel <= index;
      end
    end else if (release_now) begin
      state <= ST_IDLE;
      ptr <= ptr_nxt;
      beat_cnt <= '0;
      grant <= GNT_NONE;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_3to1.sv
// tb_bus_arbiter_3to1: directed self-checking bench for bus_arbiter_3to1.
// Define ARB_FIXED_PRIO_EN to exercise the strict-priority build instead of round-robin.
module tb_bus_arbiter_3to1;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] req;
  logic [31:0] data0, data1, data2;
  logic out_ready;
  logic [1:0] sel;
  logic [2:0] grant;
  logic [31:0] out_data;
  logic out_valid;
  logic [2:0] ack;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_d [3];

  bus_arbiter_3to1 #(.WIDTH(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1), .data2(data2),
    .out_ready(out_ready), .sel(sel), .grant(grant), .out_data(out_data),
    .out_valid(out_valid), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
  endtask

  initial begin
    reset = 1'b1;
    req = 3'b000;
    data0 = '0;
    data1 = '0;
    data2 = '0;
    out_ready = 1'b0;
    step();
    step();
    chk_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle("idle_noreq");
    end
`ifndef ARB_FIXED_PRIO_EN
    data0 = 32'd3;
    data1 = 32'd4;
    data2 = 32'd2;
    exp_d[0] = 32'd3;
    exp_d[1] = 32'd4;
    exp_d[2] = 32'd2;
    req = 3'b111;
    out_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < 4; b++) begin
        step();
        chk("rr_grant", 32'(grant), 32'(1 << g));
        chk("rr_sel", 32'(sel), 32'(g));
        chk("rr_data", out_data, exp_d[g]);
        chk("rr_ack", 32'(ack), 32'(1 << g));
      end
      step();
      chk("rr_bubble_grant", 32'(grant), 0);
      chk("rr_bubble_valid", 32'(out_valid), 0);
    end
    req = 3'b000;
    out_ready = 1'b0;
    req = 3'b010;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stall_grant", 32'(grant), 32'h2);
      chk("stall_sel", 32'(sel), 1);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_ack", 32'(ack), 0);
    end
    out_ready = 1'b1;
    step();
    chk("stall_ack_go", 32'(ack), 32'h2);
    chk("stall_data", out_data, 32'd4);
    out_ready = 1'b0;
    req = 3'b000;
    step();
    chk("stall_release", 32'(grant), 0);
    req = 3'b100;
    out_ready = 1'b1;
    step();
    chk("drop_grant", 32'(grant), 32'h4);
    chk("drop_data", out_data, 32'd2);
    step();
    chk("drop_ack", 32'(ack), 32'h4);
    step();
    chk("drop_valid", 32'(out_valid), 1);
    req = 3'b011;
    step();
    chk("drop_release_grant", 32'(grant), 0);
    chk("drop_release_ack", 32'(ack), 0);
    step();
    chk("wrap_grant", 32'(grant), 32'h1);
    chk("wrap_sel", 32'(sel), 0);
    req = 3'b000;
    step();
    chk("rst_pre_idle", 32'(grant), 0);
    req = 3'b110;
    step();
    chk("rst_pre_grant", 32'(grant), 32'h2);
    chk("rst_pre_valid", 32'(out_valid), 1);
    reset = 1'b1;
    step();
    chk_idle("rst_mid");
    reset = 1'b0;
    step();
    chk("rst_after_grant", 32'(grant), 32'h2);
    chk("rst_after_sel", 32'(sel), 1);
    req = 3'b000;
    step();
    chk("rst2_pre_idle", 32'(grant), 0);
    reset = 1'b1;
    step();
    chk_idle("rst2");
    reset = 1'b0;
    req = 3'b101;
    step();
    chk("rst2_ptr_grant", 32'(grant), 32'h1);
    chk("rst2_ptr_data", out_data, 32'd3);
`else
    data0 = 32'd3;
    data1 = 32'd4;
    data2 = 32'd2;
    req = 3'b111;
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int b = 0; b < 4; b++) begin
        step();
        chk("fp_grant", 32'(grant), 32'h1);
        chk("fp_data", out_data, 32'd3);
        chk("fp_ack", 32'(ack), 32'h1);
      end
      step();
      chk("fp_bubble", 32'(grant), 0);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
